tile_plane_serializer: RTL and testbench

Parametrised successor to the tilemap pixel output stage: NUM_PLANES independent tile planes, each with a one-tile fetch buffer, a DELAY-deep tile pipeline, per-plane fine-X scroll and per-tile horizontal flip. It also generates the pixel-clock enable and a configurable palette width. Per-plane overrun and underrun status flags are kept. The block sits between the GFX ROM fetch logic and the priority/palette mixer, and runs entirely on the 24 MHz master clock.

---
 rtl/tile_pkg.sv | 21 ++
 rtl/tile_plane_pipe.sv | 93 +++++++++
 rtl/tile_plane_serializer.sv | 70 +++++++
 tb/tb_tile_plane_serializer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Shared constants, types and pixel helper for the tile plane serializer.
// The per-plane tile entry struct lives in tile_plane_pipe because its widths depend on module parameters.
package tile_pkg;

  localparam int TILE_W  = 8;
  localparam int MAX_BPP = 8;

  typedef logic [2:0] pix_pos_t;

  // Bit b of pixel x is at data[b*TILE_W + x]. Unused upper planes must be zero.
  function automatic logic [MAX_BPP-1:0] pix_extract(
    input logic [MAX_BPP*TILE_W-1:0] data,
    input pix_pos_t                  x
  );
    logic [MAX_BPP-1:0] pix;
    pix = '0;
    for (int b = 0; b < MAX_BPP; b++) pix[b] = data[b*TILE_W + int'(x)];
    return pix;
  endfunction

endpackage

// File: rtl/tile_plane_pipe.sv
// One tile plane: a single-entry fetch buffer, a DELAY-deep tile pipeline,
// scroll/flip pixel select, and sticky overrun/underrun flags.
module tile_plane_pipe
  import tile_pkg::*;
#(
  parameter int BPP   = 4,
  parameter int PAL_W = 4,
  parameter int DELAY = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pix_ce,
  input  pix_pos_t               hcnt,
  input  pix_pos_t               fine_x,
  input  logic                   vc_valid,
  input  logic [BPP*TILE_W-1:0]  vc,
  input  logic [PAL_W-1:0]       col,
  input  logic                   flip,
  input  logic                   clr_flags,
  output logic [PAL_W+BPP-1:0]   dout,
  output logic                   opaque,
  output logic                   overrun,
  output logic                   underrun
);

  typedef struct packed {
    logic [BPP*TILE_W-1:0] data;
    logic [PAL_W-1:0]      pal;
    logic                  flip;
  } tile_entry_t;

  tile_entry_t buf_q;
  logic        buf_full;
  tile_entry_t stage_q [DELAY];

  tile_entry_t                  disp;
  tile_entry_t                  incoming;
  pix_pos_t                     pos;
  pix_pos_t                     x;
  logic                         boundary;
  logic [MAX_BPP*TILE_W-1:0]    data_ext;
  logic [MAX_BPP-1:0]           pix_full;
  logic [BPP-1:0]               color;

  // NOTE: every variable is assigned at the top of the block on every pass, so no latch can be inferred.
  always_comb begin
    disp     = stage_q[DELAY-1];
    incoming = tile_entry_t'({vc, col, flip});
    pos      = hcnt + fine_x;
    x        = disp.flip ? ~pos : pos;
    boundary = pix_ce && (pos == pix_pos_t'(TILE_W-1));
    data_ext = '0;
    data_ext[BPP*TILE_W-1:0] = disp.data;
    pix_full = pix_extract(data_ext, x);
    color    = pix_full[BPP-1:0];
  end

  // NOTE: the stages are a handful of flops, not a RAM, so they are reset to the transparent tile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q    <= '0;
      buf_full <= 1'b0;
      for (int i = 0; i < DELAY; i++) stage_q[i] <= '0;
      dout     <= '0;
      opaque   <= 1'b0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (boundary) begin
        stage_q[0] <= buf_full ? buf_q : '0;
        for (int i = 1; i < DELAY; i++) stage_q[i] <= stage_q[i-1];
      end

      // A write coincident with a boundary refills the buffer that is being drained.
      if (vc_valid) begin
        buf_q    <= incoming;
        buf_full <= 1'b1;
      end else if (boundary) begin
        buf_full <= 1'b0;
      end

      if (pix_ce) begin
        dout   <= {disp.pal, color};
        opaque <= |color;
      end

      // Setting beats clearing when both happen in the same cycle.
      overrun  <= (overrun  & ~clr_flags) | (vc_valid & buf_full & ~boundary);
      underrun <= (underrun & ~clr_flags) | (boundary & ~buf_full);
    end
  end

endmodule

// File: rtl/tile_plane_serializer.sv
// Tile plane output stage: pixel-clock divider, pixel-in-tile counter and
// NUM_PLANES independent tile plane pipelines.
module tile_plane_serializer
  import tile_pkg::*;
#(
  parameter int NUM_PLANES = 3,
  parameter int BPP        = 4,
  parameter int PAL_W      = 4,
  parameter int DELAY      = 2,
  parameter int CLK_DIV    = 4
) (
  input  logic                               clk_24M,
  input  logic                               nRES,
  input  logic                               line_start,
  input  logic [NUM_PLANES-1:0]              vc_valid,
  input  logic [NUM_PLANES*BPP*TILE_W-1:0]   vc,
  input  logic [NUM_PLANES*PAL_W-1:0]        col,
  input  logic [NUM_PLANES-1:0]              flip,
  input  logic [NUM_PLANES*3-1:0]            fine_x,
  input  logic                               clr_flags,
  output logic                               pix_ce,
  output logic [2:0]                         hcnt,
  output logic [NUM_PLANES*(PAL_W+BPP)-1:0]  dout,
  output logic [NUM_PLANES-1:0]              opaque,
  output logic [NUM_PLANES-1:0]              overrun,
  output logic [NUM_PLANES-1:0]              underrun
);

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_24M or negedge nRES) begin
    if (!nRES) begin
      cnt    <= '0;
      pix_ce <= 1'b0;
      hcnt   <= '0;
    end else begin
      cnt    <= (cnt == CNT_W'(CLK_DIV-1)) ? '0 : cnt + CNT_W'(1);
      // Registered copy of (cnt == CLK_DIV-1): decoded one count early.
      pix_ce <= (cnt == CNT_W'(CLK_DIV-2));
      if (pix_ce) hcnt <= line_start ? 3'd0 : hcnt + 3'd1;
    end
  end

  for (genvar p = 0; p < NUM_PLANES; p++) begin : g_plane
    tile_plane_pipe #(
      .BPP   (BPP),
      .PAL_W (PAL_W),
      .DELAY (DELAY)
    ) u_pipe (
      .clk       (clk_24M),
      .rst_n     (nRES),
      .pix_ce    (pix_ce),
      .hcnt      (hcnt),
      .fine_x    (fine_x[p*3 +: 3]),
      .vc_valid  (vc_valid[p]),
      .vc        (vc[p*BPP*TILE_W +: BPP*TILE_W]),
      .col       (col[p*PAL_W +: PAL_W]),
      .flip      (flip[p]),
      .clr_flags (clr_flags),
      .dout      (dout[p*(PAL_W+BPP) +: PAL_W+BPP]),
      .opaque    (opaque[p]),
      .overrun   (overrun[p]),
      .underrun  (underrun[p])
    );
  end

endmodule

// File: tb/tb_tile_plane_serializer.sv
// Directed bench for tile_plane_serializer: 3 planes, BPP=4, PAL_W=4, DELAY=1, CLK_DIV=4.
module tb_tile_plane_serializer;

  localparam int NP      = 3;
  localparam int BPP     = 4;
  localparam int PAL_W   = 4;
  localparam int DELAY   = 1;
  localparam int CLK_DIV = 4;

  logic              clk_24M = 1'b0;
  logic              nRES;
  logic              line_start;
  logic [NP-1:0]     vc_valid;
  logic [NP*32-1:0]  vc;
  logic [NP*4-1:0]   col;
  logic [NP-1:0]     flip;
  logic [NP*3-1:0]   fine_x;
  logic              clr_flags;
  logic              pix_ce;
  logic [2:0]        hcnt;
  logic [NP*8-1:0]   dout;
  logic [NP-1:0]     opaque;
  logic [NP-1:0]     overrun;
  logic [NP-1:0]     underrun;

  int checks = 0;
  int errors = 0;

  // Tiles as 8 nibbles, pixel x in bits [4x+3:4x].
  localparam logic [31:0] T1 = 32'h8765_4321;
  localparam logic [31:0] TX = 32'h5555_5555;
  localparam logic [31:0] TY = 32'h89AB_CDEF;
  localparam logic [31:0] TP = 32'h2468_ACE1;
  localparam logic [31:0] TQ = 32'h1357_9BDF;

  tile_plane_serializer #(
    .NUM_PLANES (NP),
    .BPP        (BPP),
    .PAL_W      (PAL_W),
    .DELAY      (DELAY),
    .CLK_DIV    (CLK_DIV)
  ) dut (
    .clk_24M    (clk_24M),
    .nRES       (nRES),
    .line_start (line_start),
    .vc_valid   (vc_valid),
    .vc         (vc),
    .col        (col),
    .flip       (flip),
    .fine_x     (fine_x),
    .clr_flags  (clr_flags),
    .pix_ce     (pix_ce),
    .hcnt       (hcnt),
    .dout       (dout),
    .opaque     (opaque),
    .overrun    (overrun),
    .underrun   (underrun)
  );

  always #5 clk_24M = ~clk_24M;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] nib(input logic [31:0] t, input int i);
    return t[4*i +: 4];
  endfunction

  // Nibble-per-pixel tile to ROM bit-plane layout: bit b of pixel x at [b*8 + x].
  function automatic logic [31:0] to_planes(input logic [31:0] t);
    logic [31:0] d;
    d = '0;
    for (int x = 0; x < 8; x++)
      for (int b = 0; b < 4; b++) d[b*8 + x] = t[4*x + b];
    return d;
  endfunction

  function automatic logic [7:0] pl_dout(input int p);
    return dout[p*8 +: 8];
  endfunction

  task automatic tick();
    @(posedge clk_24M);
    #1;
  endtask

  task automatic wait_pix();
    int n;
    n = 0;
    while (pix_ce !== 1'b1 && n < 2*CLK_DIV) begin
      tick();
      n++;
    end
    if (pix_ce !== 1'b1) check("pix_ce_timeout", 32'(pix_ce), 32'd1);
  endtask

  task automatic pixel();
    wait_pix();
    tick();
  endtask

  task automatic run_to(input int h);
    int n;
    n = 0;
    do begin
      pixel();
      n++;
    end while (32'(hcnt) != h && n < 16);
    check("run_to_hcnt", 32'(hcnt), 32'(h));
  endtask

  task automatic load(input int p, input logic [31:0] t, input logic [3:0] c, input logic f);
    vc[p*32 +: 32] = to_planes(t);
    col[p*4 +: 4]  = c;
    flip[p]        = f;
    vc_valid       = '0;
    vc_valid[p]    = 1'b1;
    tick();
    vc_valid       = '0;
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
  endtask

  initial begin
    nRES = 1'b0; line_start = 1'b0; vc_valid = '0; vc = '0; col = '0;
    flip = '0; fine_x = '0; clr_flags = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_pix_ce", 32'(pix_ce), 32'd0);
    check("rst_hcnt", 32'(hcnt), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_opaque", 32'(opaque), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);

    // Divider: pix_ce high during every 4th cycle after release
    nRES = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("div_pix_ce", 32'(pix_ce), (k % 4 == 3) ? 32'd1 : 32'd0);
    end
    check("div_hcnt", 32'(hcnt), 32'd3);
    for (int n = 4; n <= 8; n++) begin
      pixel();
      check("hcnt_seq", 32'(hcnt), 32'(n % 8));
      check("idle_dout", 32'(dout), 32'd0);
      check("idle_opaque", 32'(opaque), 32'd0);
    end
    check("empty_underrun", 32'(underrun), 32'b111);
    pulse_clr();
    check("clr_underrun", 32'(underrun), 32'd0);
    check("clr_overrun", 32'(overrun), 32'd0);

    // Plane 0 normal tile, plane 1 double load (overrun), plane 2 starved
    pixel();
    load(0, T1, 4'hA, 1'b0);
    load(1, TX, 4'h3, 1'b0);
    load(1, TY, 4'h3, 1'b0);
    check("ovr_set", 32'(overrun), 32'b010);
    check("ovr_no_underrun", 32'(underrun), 32'd0);
    run_to(0);
    check("bnd_underrun", 32'(underrun), 32'b100);
    check("ovr_sticky", 32'(overrun), 32'b010);
    load(0, T1, 4'hA, 1'b1);
    for (int i = 0; i < 8; i++) begin
      pixel();
      check("p0_noflip", 32'(pl_dout(0)), 32'(8'hA1 + 8'(i)));
      check("p0_opaque", 32'(opaque[0]), 32'd1);
      check("p1_second_tile", 32'(pl_dout(1)), 32'(8'h3F - 8'(i)));
      check("p2_dout_zero", 32'(pl_dout(2)), 32'd0);
      check("p2_transparent", 32'(opaque[2]), 32'd0);
    end
    pulse_clr();
    check("clr_overrun2", 32'(overrun[1]), 32'd0);

    // Horizontal flip
    for (int i = 0; i < 8; i++) begin
      pixel();
      check("p0_flip", 32'(pl_dout(0)), 32'(8'hA8 - 8'(i)));
    end

    // Fine scroll 3: boundary at hcnt=4, pixel order preserved
    fine_x[2:0] = 3'd3;
    load(0, T1, 4'hA, 1'b0);
    for (int i = 0; i < 4; i++) begin
      pixel();
      check("fx_pre_zero", 32'(pl_dout(0)), 32'd0);
    end
    pixel();
    check("fx_bnd_hcnt", 32'(hcnt), 32'd5);
    for (int i = 0; i < 8; i++) begin
      pixel();
      check("p0_fine_x", 32'(pl_dout(0)), 32'(8'hA1 + 8'(i)));
    end

    // Load coincident with a boundary on a full buffer
    pulse_clr();
    load(1, TP, 4'h5, 1'b0);
    run_to(7);
    wait_pix();
    load(1, TQ, 4'h6, 1'b0);
    check("coinc_no_overrun", 32'(overrun[1]), 32'd0);
    check("coinc_no_underrun", 32'(underrun[1]), 32'd0);
    for (int i = 0; i < 8; i++) begin
      pixel();
      check("coinc_first", 32'(pl_dout(1)), 32'({4'h5, nib(TP, i)}));
    end
    check("coinc_mid_underrun", 32'(underrun[1]), 32'd0);
    for (int i = 0; i < 8; i++) begin
      pixel();
      check("coinc_second", 32'(pl_dout(1)), 32'({4'h6, nib(TQ, i)}));
    end
    check("coinc_overrun_end", 32'(overrun[1]), 32'd0);

    // Flag set in the same cycle as clear wins
    run_to(7);
    wait_pix();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("set_beats_clr", 32'(underrun), 32'b110);
    check("set_beats_clr_ovr", 32'(overrun), 32'd0);

    // Asynchronous reset mid-line discards the buffered tile
    load(0, T1, 4'hA, 1'b0);
    @(posedge clk_24M);
    #2 nRES = 1'b0;
    #1;
    check("async_dout", 32'(dout), 32'd0);
    check("async_flags", 32'({overrun, underrun}), 32'd0);
    check("async_hcnt", 32'(hcnt), 32'd0);
    check("async_pix_ce", 32'(pix_ce), 32'd0);
    tick();
    nRES = 1'b1;
    repeat (5) pixel();
    check("rst_discard_underrun", 32'(underrun), 32'b001);
    check("rst_discard_dout", 32'(dout), 32'd0);

    // line_start reloads hcnt
    line_start = 1'b1;
    pixel();
    line_start = 1'b0;
    check("line_start_hcnt", 32'(hcnt), 32'd0);
    pixel();
    check("line_start_next", 32'(hcnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
